// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: fetch prediction, EX resolve and predictor-update signals of the branch resolve queue.
interface branch_resolve_queue_if #(
  parameter int QUEUE_DEPTH = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int GHR_WIDTH   = 8
);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  logic                  Pred_Valid;
  logic                  Pred_Taken;
  logic [ADDR_WIDTH-1:0] Pred_PC;
  logic [ADDR_WIDTH-1:0] Pred_Target;
  logic [GHR_WIDTH-1:0]  Pred_GHR;
  logic                  Resolve_Valid;
  logic                  Resolve_Taken;
  logic [ADDR_WIDTH-1:0] Resolve_Target;
  logic                  Queue_Full;
  logic                  Stall_IF;
  logic                  Br_Dectected;
  logic                  Br_Comp_Result;
  logic                  BHB_Update_En;
  logic [GHR_WIDTH-1:0]  BHB_Update_Idx;
  logic                  Mispredict;
  logic [ADDR_WIDTH-1:0] Redirect_PC;
  logic [CW-1:0]         Queue_Count;
  logic                  Resolve_Err;
  modport master (
    output Pred_Valid, Pred_Taken, Pred_PC, Pred_Target, Pred_GHR,
    output Resolve_Valid, Resolve_Taken, Resolve_Target,
    input  Queue_Full, Stall_IF, Br_Dectected, Br_Comp_Result, BHB_Update_En,
    input  BHB_Update_Idx, Mispredict, Redirect_PC, Queue_Count, Resolve_Err
  );
  modport slave (
    input  Pred_Valid, Pred_Taken, Pred_PC, Pred_Target, Pred_GHR,
    input  Resolve_Valid, Resolve_Taken, Resolve_Target,
    output Queue_Full, Stall_IF, Br_Dectected, Br_Comp_Result, BHB_Update_En,
    output BHB_Update_Idx, Mispredict, Redirect_PC, Queue_Count, Resolve_Err
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: in-order queue of fetch predictions checked against EX outcomes, driving predictor update and mispredict redirect.
module branch_resolve_queue #(
  parameter int QUEUE_DEPTH    = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int GHR_WIDTH      = 8,
  parameter int RECOVER_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  branch_resolve_queue_if.slave bus
);
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = $clog2(RECOVER_CYCLES + 1);
  typedef enum logic {RUN, RECOVER} state_t;
  state_t state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic                  ent_taken_q [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] ent_pc_q    [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] ent_tgt_q   [QUEUE_DEPTH];
  logic [GHR_WIDTH-1:0]  ent_ghr_q   [QUEUE_DEPTH];
  logic full, pop, push, mis;
  logic [ADDR_WIDTH-1:0] redir;
  logic det_q, res_q, mis_q, err_q;
  logic [GHR_WIDTH-1:0] idx_q;
  logic [ADDR_WIDTH-1:0] redir_q;
  always_comb begin
    full    = count_q == CW'(QUEUE_DEPTH);
    pop     = bus.Resolve_Valid && count_q != '0;
    mis     = pop && (ent_taken_q[rd_q] != bus.Resolve_Taken ||
              (bus.Resolve_Taken && ent_tgt_q[rd_q] != bus.Resolve_Target));
    push    = state_q == RUN && bus.Pred_Valid && (!full || pop) && !mis;
    rd_d    = rd_q + PW'(pop);
    // a mispredict discards every younger entry, so the write side snaps back to the new head
    wr_d    = mis ? rd_d : wr_q + PW'(push);
    count_d = mis ? '0 : count_q + CW'(push) - CW'(pop);
    redir   = bus.Resolve_Taken ? bus.Resolve_Target : ent_pc_q[rd_q] + ADDR_WIDTH'(4);
  end
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    if (state_q == RUN) begin
      if (mis) begin
        state_d = RECOVER;
        rcnt_d  = RW'(RECOVER_CYCLES);
      end
    end else begin
      rcnt_d = rcnt_q - 1'b1;
      if (rcnt_q == RW'(1)) state_d = RUN;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      rcnt_q  <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      det_q   <= 1'b0;
      res_q   <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      idx_q   <= '0;
      redir_q <= '0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
      det_q   <= pop;
      res_q   <= pop && bus.Resolve_Taken;
      mis_q   <= mis;
      err_q   <= err_q || (bus.Resolve_Valid && count_q == '0);
      idx_q   <= pop ? ent_ghr_q[rd_q] : '0;
      redir_q <= mis ? redir : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      ent_taken_q[wr_q] <= bus.Pred_Taken;
      ent_pc_q[wr_q]    <= bus.Pred_PC;
      ent_tgt_q[wr_q]   <= bus.Pred_Target;
      ent_ghr_q[wr_q]   <= bus.Pred_GHR;
    end
  end
  assign bus.Queue_Full     = full;
  assign bus.Stall_IF       = full || state_q == RECOVER;
  assign bus.Br_Dectected   = det_q;
  assign bus.Br_Comp_Result = res_q;
  assign bus.BHB_Update_En  = det_q;
  assign bus.BHB_Update_Idx = idx_q;
  assign bus.Mispredict     = mis_q;
  assign bus.Redirect_PC    = redir_q;
  assign bus.Queue_Count    = count_q;
  assign bus.Resolve_Err    = err_q;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed scenario tasks with hand-computed expectations for branch_resolve_queue.
module tb_branch_resolve_queue;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  branch_resolve_queue_if #(.QUEUE_DEPTH(4), .ADDR_WIDTH(32), .GHR_WIDTH(8)) bus ();
  branch_resolve_queue #(.QUEUE_DEPTH(4), .ADDR_WIDTH(32), .GHR_WIDTH(8), .RECOVER_CYCLES(2))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.Pred_Valid = 0; bus.Pred_Taken = 0; bus.Pred_PC = '0; bus.Pred_Target = '0; bus.Pred_GHR = '0;
    bus.Resolve_Valid = 0; bus.Resolve_Taken = 0; bus.Resolve_Target = '0;
  endtask

  task automatic set_pred(input logic t, input logic [31:0] pc, input logic [31:0] tgt, input logic [7:0] ghr);
    bus.Pred_Valid = 1; bus.Pred_Taken = t; bus.Pred_PC = pc; bus.Pred_Target = tgt; bus.Pred_GHR = ghr;
  endtask

  task automatic set_res(input logic t, input logic [31:0] tgt);
    bus.Resolve_Valid = 1; bus.Resolve_Taken = t; bus.Resolve_Target = tgt;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    checks++;
    if ({bus.Br_Dectected, bus.Br_Comp_Result, bus.BHB_Update_En, bus.Mispredict, bus.Resolve_Err,
         bus.Queue_Full, bus.Stall_IF} !== 7'd0) begin
      errors++; $display("FAIL reset_flags got %b exp 0000000", {bus.Br_Dectected, bus.Br_Comp_Result,
        bus.BHB_Update_En, bus.Mispredict, bus.Resolve_Err, bus.Queue_Full, bus.Stall_IF});
    end
    checks++;
    if ({bus.Queue_Count, bus.BHB_Update_Idx, bus.Redirect_PC} !== '0) begin
      errors++; $display("FAIL reset_values got count %0d idx %h pc %h exp 0", bus.Queue_Count, bus.BHB_Update_Idx, bus.Redirect_PC);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      set_pred(0, 32'h100 + 32'(i) * 32'h10, 32'h0, 8'(i + 1));
      tick();
    end
    checks++;
    if (bus.Queue_Count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", bus.Queue_Count); end
    checks++;
    if ({bus.Queue_Full, bus.Stall_IF} !== 2'b11) begin
      errors++; $display("FAIL fill_full_stall got %b exp 11", {bus.Queue_Full, bus.Stall_IF});
    end
    set_pred(0, 32'h140, 32'h0, 8'h55);
    tick();
    idle_inputs();
    checks++;
    if (bus.Queue_Count !== 3'd4) begin errors++; $display("FAIL overflow_count got %0d exp 4", bus.Queue_Count); end
  endtask

  task automatic test_resolve_ok();
    set_res(0, 32'h0);
    tick();
    idle_inputs();
    checks++;
    if ({bus.Br_Dectected, bus.Br_Comp_Result, bus.BHB_Update_En, bus.Mispredict} !== 4'b1010) begin
      errors++; $display("FAIL ok_pulse got %b exp 1010", {bus.Br_Dectected, bus.Br_Comp_Result, bus.BHB_Update_En, bus.Mispredict});
    end
    checks++;
    if (bus.Queue_Count !== 3'd3 || bus.BHB_Update_Idx !== 8'h01) begin
      errors++; $display("FAIL ok_count_idx got %0d/%h exp 3/01", bus.Queue_Count, bus.BHB_Update_Idx);
    end
    tick();
    checks++;
    if ({bus.Br_Dectected, bus.BHB_Update_En} !== 2'b00) begin
      errors++; $display("FAIL ok_pulse_width got %b exp 00", {bus.Br_Dectected, bus.BHB_Update_En});
    end
    for (int i = 0; i < 3; i++) begin
      set_res(0, 32'h0);
      tick();
      checks++;
      if (bus.BHB_Update_Idx !== 8'(i + 2) || bus.Mispredict !== 1'b0) begin
        errors++; $display("FAIL drain_order%0d got idx %h mis %b exp %h 0", i, bus.BHB_Update_Idx, bus.Mispredict, 8'(i + 2));
      end
    end
    idle_inputs();
    checks++;
    if (bus.Queue_Count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", bus.Queue_Count); end
  endtask

  task automatic test_mispredict_target();
    set_pred(1, 32'h1F0, 32'h200, 8'h33);
    tick();
    set_pred(0, 32'h210, 32'h0, 8'h34);
    tick();
    set_res(1, 32'h240);
    set_pred(0, 32'h220, 32'h0, 8'h35);
    tick();
    bus.Resolve_Valid = 0;
    checks++;
    if (bus.Mispredict !== 1'b1 || bus.Redirect_PC !== 32'h240) begin
      errors++; $display("FAIL tgt_mis got %b %h exp 1 00000240", bus.Mispredict, bus.Redirect_PC);
    end
    checks++;
    if (bus.Queue_Count !== 3'd0 || bus.Stall_IF !== 1'b1 || bus.Br_Comp_Result !== 1'b1) begin
      errors++; $display("FAIL tgt_flush got count %0d stall %b res %b exp 0 1 1", bus.Queue_Count, bus.Stall_IF, bus.Br_Comp_Result);
    end
    tick();
    checks++;
    if (bus.Stall_IF !== 1'b1 || bus.Queue_Count !== 3'd0 || bus.Mispredict !== 1'b0) begin
      errors++; $display("FAIL recover1 got stall %b count %0d mis %b exp 1 0 0", bus.Stall_IF, bus.Queue_Count, bus.Mispredict);
    end
    tick();
    idle_inputs();
    checks++;
    if (bus.Stall_IF !== 1'b0 || bus.Queue_Count !== 3'd0) begin
      errors++; $display("FAIL recover_end got stall %b count %0d exp 0 0", bus.Stall_IF, bus.Queue_Count);
    end
  endtask

  task automatic test_mispredict_dir();
    set_pred(1, 32'h300, 32'h400, 8'hA5);
    tick();
    idle_inputs();
    set_res(0, 32'h0);
    tick();
    idle_inputs();
    checks++;
    if (bus.Mispredict !== 1'b1 || bus.Redirect_PC !== 32'h304) begin
      errors++; $display("FAIL dir_redirect got %b %h exp 1 00000304", bus.Mispredict, bus.Redirect_PC);
    end
    checks++;
    if (bus.BHB_Update_Idx !== 8'hA5 || bus.Br_Comp_Result !== 1'b0) begin
      errors++; $display("FAIL dir_idx got %h %b exp a5 0", bus.BHB_Update_Idx, bus.Br_Comp_Result);
    end
    tick(); tick();
    set_pred(1, 32'hFFFF_FFFC, 32'h10, 8'h01);
    tick();
    idle_inputs();
    set_res(0, 32'h0);
    tick();
    idle_inputs();
    checks++;
    if (bus.Mispredict !== 1'b1 || bus.Redirect_PC !== 32'h0) begin
      errors++; $display("FAIL wrap_redirect got %b %h exp 1 00000000", bus.Mispredict, bus.Redirect_PC);
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      set_pred(0, 32'h500 + 32'(i) * 32'h10, 32'h0, 8'(8'h10 + i));
      tick();
    end
    for (int i = 0; i < 12; i++) begin
      set_pred(0, 32'h540 + 32'(i) * 32'h10, 32'h0, 8'(8'h14 + i));
      set_res(0, 32'h0);
      tick();
      checks++;
      if (bus.Queue_Count !== 3'd4 || bus.Queue_Full !== 1'b1 || bus.BHB_Update_Idx !== 8'(8'h10 + i) || bus.Mispredict !== 1'b0) begin
        errors++; $display("FAIL b2b%0d got count %0d full %b idx %h mis %b exp 4 1 %h 0",
          i, bus.Queue_Count, bus.Queue_Full, bus.BHB_Update_Idx, bus.Mispredict, 8'(8'h10 + i));
      end
    end
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      set_res(0, 32'h0);
      tick();
      checks++;
      if (bus.BHB_Update_Idx !== 8'(8'h1C + i)) begin
        errors++; $display("FAIL b2b_drain%0d got %h exp %h", i, bus.BHB_Update_Idx, 8'(8'h1C + i));
      end
    end
    idle_inputs();
    tick();
    checks++;
    if (bus.Queue_Count !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", bus.Queue_Count); end
  endtask

  task automatic test_empty_resolve();
    set_res(0, 32'h0);
    set_pred(0, 32'h600, 32'h0, 8'h77);
    tick();
    idle_inputs();
    checks++;
    if (bus.Resolve_Err !== 1'b1 || bus.Br_Dectected !== 1'b0 || bus.Queue_Count !== 3'd1) begin
      errors++; $display("FAIL empty_err got err %b det %b count %0d exp 1 0 1", bus.Resolve_Err, bus.Br_Dectected, bus.Queue_Count);
    end
    set_res(0, 32'h0);
    tick();
    idle_inputs();
    tick();
    checks++;
    if (bus.Resolve_Err !== 1'b1 || bus.Queue_Count !== 3'd0) begin
      errors++; $display("FAIL err_sticky got err %b count %0d exp 1 0", bus.Resolve_Err, bus.Queue_Count);
    end
  endtask

  task automatic test_reset_mid_recover();
    set_pred(1, 32'h700, 32'h800, 8'h42);
    tick();
    set_pred(0, 32'h710, 32'h0, 8'h43);
    tick();
    idle_inputs();
    set_res(0, 32'h0);
    tick();
    idle_inputs();
    checks++;
    if (bus.Mispredict !== 1'b1 || bus.Stall_IF !== 1'b1) begin
      errors++; $display("FAIL pre_reset got mis %b stall %b exp 1 1", bus.Mispredict, bus.Stall_IF);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({bus.Mispredict, bus.Stall_IF, bus.Br_Dectected, bus.Resolve_Err, bus.Queue_Count, bus.Redirect_PC, bus.BHB_Update_Idx} !== '0) begin
      errors++; $display("FAIL async_reset got mis %b stall %b det %b err %b count %0d pc %h idx %h exp all 0",
        bus.Mispredict, bus.Stall_IF, bus.Br_Dectected, bus.Resolve_Err, bus.Queue_Count, bus.Redirect_PC, bus.BHB_Update_Idx);
    end
    @(negedge clk);
    rst_n = 1;
    set_pred(0, 32'h900, 32'h0, 8'h99);
    tick();
    idle_inputs();
    set_res(0, 32'h0);
    tick();
    idle_inputs();
    checks++;
    if (bus.Br_Dectected !== 1'b1 || bus.BHB_Update_Idx !== 8'h99 || bus.Queue_Count !== 3'd0) begin
      errors++; $display("FAIL post_reset_run got det %b idx %h count %0d exp 1 99 0", bus.Br_Dectected, bus.BHB_Update_Idx, bus.Queue_Count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_resolve_ok();
    test_mispredict_target();
    test_mispredict_dir();
    test_back_to_back();
    test_empty_resolve();
    test_reset_mid_recover();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
